// File: rtl/row_writer_sdram_if.sv
// row_writer_sdram_if: camera-side pixel stream and SDRAM write port
// of the row writer, grouped so the bench and the DUT share one bundle.
interface row_writer_sdram_if;
    logic         frame_start;
    logic         pixel_valid;
    logic [15:0]  pixel_data;
    logic         ram_busy;
    logic         wr_req;
    logic [24:0]  wr_address;
    logic [255:0] wr_data;
    logic [2:0]   last_frame;
    logic         frame_done;
    logic         overflow;

    modport master (
        output frame_start,
        output pixel_valid,
        output pixel_data,
        output ram_busy,
        input  wr_req,
        input  wr_address,
        input  wr_data,
        input  last_frame,
        input  frame_done,
        input  overflow
    );

    modport slave (
        input  frame_start,
        input  pixel_valid,
        input  pixel_data,
        input  ram_busy,
        output wr_req,
        output wr_address,
        output wr_data,
        output last_frame,
        output frame_done,
        output overflow
    );
endinterface

// File: rtl/row_writer_sdram.sv
// row_writer_sdram: packs 16-bit camera pixels into 256-bit words and
// writes them into rotating SDRAM frame slots with a req/busy handshake.
module row_writer_sdram #(
    parameter int          H_PIXELS    = 640,
    parameter int          V_LINES     = 480,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          NUM_SLOTS   = 6,
    parameter logic [24:0] SLOT_STRIDE = 25'h25800
) (
    input  logic              clk_133M,
    input  logic              rst_133M,
    row_writer_sdram_if.slave bus
);

    localparam int          WORDS       = H_PIXELS * V_LINES / 16;
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [14:0] FRAME_WORDS = 15'(WORDS);
    localparam logic [14:0] LAST_WORD   = 15'(WORDS - 1);
    localparam logic [2:0]  LAST_SLOT   = 3'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    // packer and frame position
    logic [3:0]   pix_cnt;
    logic [239:0] pack;
    logic [14:0]  word_cnt;
    logic [24:0]  base;
    logic [24:0]  slot_base;
    logic [24:0]  word_addr;
    logic [255:0] push_word;
    logic         take;
    logic         push_due;
    logic         push_ok;
    logic         push_drop;
    logic         drop_last;

    // word FIFO; each entry carries its own address and end-of-frame mark
    logic [255:0] fifo_data [FIFO_DEPTH];
    logic [24:0]  fifo_addr [FIFO_DEPTH];
    logic         fifo_last [FIFO_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic         fifo_empty;
    logic         fifo_full;

    // issue side
    state_t       state;
    logic         issue;
    logic         issue_last;
    logic         wr_req_q;
    logic [24:0]  wr_address_q;
    logic [255:0] wr_data_q;

    // slot rotation
    logic [2:0]   slot;
    logic [2:0]   last_frame_q;
    logic         frame_done_q;
    logic         overflow_q;

    assign wr_idx     = wr_ptr[AW-1:0];
    assign rd_idx     = rd_ptr[AW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW])
                     && (wr_idx == rd_idx);

    // A pixel coinciding with frame_start is pixel 0 of the new frame;
    // otherwise pixels past the frame's last word are ignored.
    assign take = bus.pixel_valid
               && (bus.frame_start || (word_cnt != FRAME_WORDS));

    assign push_due  = take && !bus.frame_start && (pix_cnt == 4'd15);
    assign push_ok   = push_due && !fifo_full;
    assign push_drop = push_due && fifo_full;
    assign drop_last = push_drop && (word_cnt == LAST_WORD);

    assign push_word = {bus.pixel_data, pack};
    assign slot_base = 25'(slot) * SLOT_STRIDE;
    assign word_addr = base + {7'd0, word_cnt, 3'd0};

    assign issue      = (state == S_IDLE) && !fifo_empty && !bus.ram_busy;
    assign issue_last = issue && fifo_last[rd_idx];

    assign bus.wr_req     = wr_req_q;
    assign bus.wr_address = wr_address_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.last_frame = last_frame_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;

    // Shift pixels in from the top so pixel 0 ends in the LSBs, count
    // words per frame and push (or drop) each completed word.
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            pix_cnt    <= '0;
            pack       <= '0;
            word_cnt   <= '0;
            base       <= '0;
            wr_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (take)
                pack <= {bus.pixel_data, pack[239:16]};
            if (bus.frame_start) begin
                pix_cnt  <= {3'd0, take};
                word_cnt <= '0;
                base     <= slot_base;
            end else if (take) begin
                pix_cnt <= pix_cnt + 4'd1;
                if (push_due)
                    word_cnt <= word_cnt + 15'd1;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (push_drop)
                overflow_q <= 1'b1;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_133M) begin
        if (push_ok) begin
            fifo_data[wr_idx] <= push_word;
            fifo_addr[wr_idx] <= word_addr;
            fifo_last[wr_idx] <= (word_cnt == LAST_WORD);
        end
    end

    // Issue FSM: one-cycle request, then a gap cycle before looking again.
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            state        <= S_IDLE;
            rd_ptr       <= '0;
            wr_req_q     <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (issue) begin
                        state        <= S_REQ;
                        wr_req_q     <= 1'b1;
                        wr_address_q <= fifo_addr[rd_idx];
                        wr_data_q    <= fifo_data[rd_idx];
                        rd_ptr       <= rd_ptr + 1'b1;
                    end
                end
                S_REQ: begin
                    wr_req_q <= 1'b0;
                    state    <= S_GAP;
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    wr_req_q <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Publish the finished slot alongside the frame's final request
    // (or drop) and move on to the next slot.
    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            slot         <= '0;
            last_frame_q <= LAST_SLOT;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= issue_last || drop_last;
            if (issue_last || drop_last) begin
                last_frame_q <= slot;
                slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_row_writer_sdram.sv
// tb_row_writer_sdram: directed checks of packing, addressing, slot
// rotation, overflow, frame restart and reset on a reduced 32x4 frame.
module tb_row_writer_sdram;

    // 32x4 frame -> 8 words per frame, slot stride 8*8 = 0x40
    localparam int          H  = 32;
    localparam int          V  = 4;
    localparam logic [24:0] ST = 25'h40;

    logic clk_133M = 1'b0;
    logic rst_133M = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [24:0]  req_addr [$];
    logic [255:0] req_data [$];
    int           done_cnt = 0;
    int           done_idx = -1;

    row_writer_sdram_if bus();

    row_writer_sdram #(
        .H_PIXELS    (H),
        .V_LINES     (V),
        .FIFO_DEPTH  (4),
        .NUM_SLOTS   (6),
        .SLOT_STRIDE (ST)
    ) dut (
        .clk_133M (clk_133M),
        .rst_133M (rst_133M),
        .bus      (bus)
    );

    always #5 clk_133M = ~clk_133M;

    // Record every request and where frame_done fell relative to them.
    always @(negedge clk_133M) begin
        if (bus.wr_req === 1'b1) begin
            req_addr.push_back(bus.wr_address);
            req_data.push_back(bus.wr_data);
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            done_idx = req_addr.size();
        end
    end

    task automatic drive(input logic fs, input logic pv,
                         input logic [15:0] pd);
        @(negedge clk_133M);
        bus.frame_start = fs;
        bus.pixel_valid = pv;
        bus.pixel_data  = pd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 16'h0);
    endtask

    // Pixel p of word w carries {w, p}.
    task automatic send_words(input int w0, input int n, input logic fs);
        for (int w = w0; w < w0 + n; w++)
            for (int p = 0; p < 16; p++)
                drive(fs && (w == w0) && (p == 0), 1'b1,
                      {w[7:0], p[7:0]});
        drive(1'b0, 1'b0, 16'h0);
    endtask

    task automatic clear_log();
        req_addr.delete();
        req_data.delete();
        done_cnt = 0;
        done_idx = -1;
    endtask

    task automatic do_reset();
        @(negedge clk_133M);
        rst_133M        = 1'b1;
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_data  = 16'h0;
        bus.ram_busy    = 1'b0;
        repeat (3) @(negedge clk_133M);
        rst_133M = 1'b0;
        @(negedge clk_133M);
        clear_log();
    endtask

    task automatic wait_reqs(input int n, input int max_cyc,
                             input string name);
        int c = 0;
        while (req_addr.size() < n && c < max_cyc) begin
            @(negedge clk_133M);
            c++;
        end
        checks++;
        if (req_addr.size() < n) begin
            failures++;
            $display("FAIL %s timeout: requests=%0d required=%0d",
                     name, req_addr.size(), n);
        end
    endtask

    task automatic wait_done(input int n, input int max_cyc,
                             input string name);
        int c = 0;
        while (done_cnt < n && c < max_cyc) begin
            @(negedge clk_133M);
            c++;
        end
        checks++;
        if (done_cnt < n) begin
            failures++;
            $display("FAIL %s frame_done timeout: got=%0d required=%0d",
                     name, done_cnt, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus.wr_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_wr_req got=%b exp=0", bus.wr_req);
        end
        if (bus.wr_address !== 25'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", bus.wr_address);
        end
        if (bus.wr_data !== 256'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", bus.wr_data);
        end
        if (bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done);
        end
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%b exp=0", bus.overflow);
        end
        if (bus.last_frame !== 3'd5) begin
            failures++;
            $display("FAIL reset_last_frame got=%0d exp=5", bus.last_frame);
        end
    endtask

    task automatic test_single_word();
        logic [255:0] exp;
        do_reset();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, 16'(i));
        idle(1);
        wait_reqs(1, 30, "single");
        idle(10);
        for (int i = 0; i < 16; i++)
            exp[16*i +: 16] = 16'(i);
        checks += 4;
        if (req_addr.size() != 1) begin
            failures++;
            $display("FAIL single_count got=%0d exp=1", req_addr.size());
        end
        if (req_addr.size() > 0) begin
            if (req_addr[0] !== 25'h0) begin
                failures++;
                $display("FAIL single_addr got=%h exp=0", req_addr[0]);
            end
            if (req_data[0][15:0] !== 16'h0000 ||
                req_data[0][255:240] !== 16'h000F) begin
                failures++;
                $display("FAIL single_ends got=%h/%h exp=0000/000f",
                         req_data[0][15:0], req_data[0][255:240]);
            end
            if (req_data[0] !== exp) begin
                failures++;
                $display("FAIL single_data got=%h exp=%h",
                         req_data[0], exp);
            end
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        send_words(0, 8, 1'b1);
        wait_done(1, 60, "full");
        idle(10);
        checks += 5;
        if (req_addr.size() != 8) begin
            failures++;
            $display("FAIL full_count got=%0d exp=8", req_addr.size());
        end
        if (done_cnt != 1 || done_idx != 8) begin
            failures++;
            $display("FAIL full_done got=%0d@%0d exp=1@8",
                     done_cnt, done_idx);
        end
        if (bus.last_frame !== 3'd0) begin
            failures++;
            $display("FAIL full_last_frame got=%0d exp=0", bus.last_frame);
        end
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_overflow got=%b exp=0", bus.overflow);
        end
        if (req_addr.size() == 8 && req_addr[7] !== 25'h38) begin
            failures++;
            $display("FAIL full_last_addr got=%h exp=38", req_addr[7]);
        end
        for (int i = 0; i < req_addr.size(); i++) begin
            checks += 2;
            if (req_addr[i] !== 25'(8 * i)) begin
                failures++;
                $display("FAIL full_addr[%0d] got=%h exp=%h",
                         i, req_addr[i], 25'(8 * i));
            end
            if (req_data[i][15:0] !== {i[7:0], 8'h00} ||
                req_data[i][255:240] !== {i[7:0], 8'h0F}) begin
                failures++;
                $display("FAIL full_data[%0d] got=%h/%h",
                         i, req_data[i][15:0], req_data[i][255:240]);
            end
        end
        // pixels past the frame's last word are discarded
        send_words(8, 1, 1'b0);
        idle(20);
        checks++;
        if (req_addr.size() != 8) begin
            failures++;
            $display("FAIL full_extra got=%0d exp=8", req_addr.size());
        end
    endtask

    task automatic test_slot_rotation();
        logic [24:0] bases [6];
        bases = '{25'h0, 25'h40, 25'h80, 25'hC0, 25'h100, 25'h140};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            clear_log();
            send_words(0, 8, 1'b1);
            wait_done(1, 60, "slots");
            idle(4);
            checks += 2;
            if (req_addr.size() == 0 || req_addr[0] !== bases[k % 6]) begin
                failures++;
                $display("FAIL slot%0d_base got=%h exp=%h", k,
                         (req_addr.size() > 0) ? req_addr[0] : 25'h1FFFFFF,
                         bases[k % 6]);
            end
            if (bus.last_frame !== 3'(k % 6)) begin
                failures++;
                $display("FAIL slot%0d_last_frame got=%0d exp=%0d",
                         k, bus.last_frame, k % 6);
            end
        end
    endtask

    task automatic test_overflow();
        logic [24:0] ea [7];
        logic [7:0]  ew [7];
        ea = '{25'h0, 25'h8, 25'h10, 25'h18, 25'h28, 25'h30, 25'h38};
        ew = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7};
        do_reset();
        bus.ram_busy = 1'b1;
        send_words(0, 5, 1'b1);
        idle(19);
        checks += 2;
        if (bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got=%b exp=1", bus.overflow);
        end
        if (req_addr.size() != 0) begin
            failures++;
            $display("FAIL ovf_busy_reqs got=%0d exp=0", req_addr.size());
        end
        bus.ram_busy = 1'b0;
        send_words(5, 3, 1'b0);
        wait_done(1, 80, "ovf");
        idle(10);
        checks += 3;
        if (req_addr.size() != 7) begin
            failures++;
            $display("FAIL ovf_count got=%0d exp=7", req_addr.size());
        end
        if (done_idx != 7 || bus.last_frame !== 3'd0) begin
            failures++;
            $display("FAIL ovf_done got=@%0d lf=%0d exp=@7 lf=0",
                     done_idx, bus.last_frame);
        end
        if (bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=1", bus.overflow);
        end
        for (int i = 0; i < req_addr.size() && i < 7; i++) begin
            checks++;
            if (req_addr[i] !== ea[i] ||
                req_data[i][15:0] !== {ew[i], 8'h00}) begin
                failures++;
                $display("FAIL ovf_req[%0d] got=%h/%h exp=%h/%h", i,
                         req_addr[i], req_data[i][15:0],
                         ea[i], {ew[i], 8'h00});
            end
        end
    endtask

    task automatic test_partial_restart();
        do_reset();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 7; i++)
            drive(1'b0, 1'b1, 16'hBAD0 + 16'(i));
        for (int i = 0; i < 16; i++)
            drive(i == 0, 1'b1, 16'h0100 + 16'(i));
        idle(1);
        wait_reqs(1, 30, "partial");
        idle(10);
        checks += 3;
        if (req_addr.size() != 1) begin
            failures++;
            $display("FAIL partial_count got=%0d exp=1", req_addr.size());
        end
        if (req_addr.size() > 0) begin
            if (req_addr[0] !== 25'h0) begin
                failures++;
                $display("FAIL partial_addr got=%h exp=0", req_addr[0]);
            end
            if (req_data[0][15:0] !== 16'h0100 ||
                req_data[0][111:96] !== 16'h0106 ||
                req_data[0][255:240] !== 16'h010F) begin
                failures++;
                $display("FAIL partial_data got=%h/%h/%h exp=0100/0106/010f",
                         req_data[0][15:0], req_data[0][111:96],
                         req_data[0][255:240]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        do_reset();
        send_words(0, 8, 1'b1);
        wait_done(1, 60, "mid_pre");
        idle(4);
        send_words(0, 1, 1'b1);
        while (bus.wr_req !== 1'b1 && c < 40) begin
            @(negedge clk_133M);
            c++;
        end
        checks += 2;
        if (bus.wr_req !== 1'b1 || bus.wr_address !== 25'h40) begin
            failures++;
            $display("FAIL mid_req_seen got=%b@%h exp=1@40",
                     bus.wr_req, bus.wr_address);
        end
        rst_133M = 1'b1;
        #1;
        if (bus.wr_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_drop got=%b exp=0", bus.wr_req);
        end
        repeat (2) @(negedge clk_133M);
        rst_133M = 1'b0;
        @(negedge clk_133M);
        clear_log();
        checks++;
        if (bus.last_frame !== 3'd5) begin
            failures++;
            $display("FAIL mid_last_frame got=%0d exp=5", bus.last_frame);
        end
        send_words(0, 1, 1'b1);
        wait_reqs(1, 30, "mid_post");
        checks++;
        if (req_addr.size() == 0 || req_addr[0] !== 25'h0) begin
            failures++;
            $display("FAIL mid_first_addr got=%h exp=0",
                     (req_addr.size() > 0) ? req_addr[0] : 25'h1FFFFFF);
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_data  = 16'h0;
        bus.ram_busy    = 1'b0;
        test_reset();
        test_single_word();
        test_full_frame();
        test_slot_rotation();
        test_overflow();
        test_partial_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
